timer_cmd_initiator: RTL

- Initiator end of the serial start/delay/done/ack timer protocol; drives a timer that waits for a 1101 start pattern.
- Accepts a parallel delay request and serializes header 1101 + 4 delay bits MSB-first on `data`.
- Then waits for `done`, handshakes `ack`, and reports completion to the local controller with a one-cycle pulse.

---
 rtl/timer_cmd_initiator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/timer_cmd_initiator.sv
// Timer initiator: sends HDR plus the delay code MSB-first on data, waits for done, acks it and pulses complete.
// Latency from start accept to the last delay bit is 8 cycles; start is ignored while busy. Optional watchdog: TIMER_CMD_WDOG_EN.
module timer_cmd_initiator #(
   parameter logic [3:0] HDR             = 4'b1101,
   parameter int         DLY_W           = 4,
   parameter int         CYCLES_PER_UNIT = 1000,
   parameter int         TIMEOUT_MARGIN  = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DLY_W-1:0] delay,
   output logic             busy,
   output logic             complete,
   output logic             timeout,
   output logic             data,
   output logic             ack,
   input  logic             counting,
   input  logic             done,
   output logic             busy_timer
);
   localparam int               CNT_W    = (DLY_W > 4) ? $clog2(DLY_W) : 2;
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(3);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEND_HDR,
      SEND_DLY,
      WAIT_DONE,
      ACK
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [DLY_W-1:0] dly_q;
   logic             dly_load;
   logic             data_nxt;
   logic             ack_nxt;
   logic             complete_nxt;
   logic             wdog_hit;

`ifdef TIMER_CMD_WDOG_EN
   localparam int WW = $clog2((2 ** DLY_W) * CYCLES_PER_UNIT + TIMEOUT_MARGIN) + 1;

   logic [WW-1:0] wcnt;
   logic [WW-1:0] limit;

   assign limit    = (WW'(dly_q) + WW'(1)) * WW'(CYCLES_PER_UNIT) + WW'(TIMEOUT_MARGIN);
   assign wdog_hit = (wcnt + WW'(1)) == limit;

   // Counter restarts from zero on every entry into WAIT_DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= (state == WAIT_DONE) && !done && wdog_hit;
         if ((state == WAIT_DONE) && !done && !wdog_hit)
            wcnt <= wcnt + WW'(1);
         else
            wcnt <= '0;
      end
   end
`else
   assign wdog_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      dly_load     = 1'b0;
      ack_nxt      = 1'b0;
      complete_nxt = 1'b0;
      case (state)
         IDLE: begin
            // A start coinciding with the complete pulse is refused.
            if (start && !complete) begin
               state_nxt = SEND_HDR;
               cnt_nxt   = '0;
               dly_load  = 1'b1;
            end
         end
         SEND_HDR: begin
            if (cnt == HDR_LAST) begin
               state_nxt = SEND_DLY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         SEND_DLY: begin
            if (cnt == DLY_LAST) begin
               state_nxt = WAIT_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (done) begin
               state_nxt = ACK;
               ack_nxt   = 1'b1;
            end else if (wdog_hit) begin
               state_nxt    = IDLE;
               complete_nxt = 1'b1;
            end
         end
         ACK: begin
            if (done) begin
               ack_nxt = 1'b1;
            end else begin
               state_nxt    = IDLE;
               complete_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Serial bit for the next cycle, selected by where the frame will be.
   always_comb begin
      data_nxt = 1'b0;
      if (state_nxt == SEND_HDR)
         data_nxt = HDR[HDR_LAST - cnt_nxt];
      else if (state_nxt == SEND_DLY)
         data_nxt = dly_q[DLY_LAST - cnt_nxt];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         dly_q      <= '0;
         data       <= 1'b0;
         ack        <= 1'b0;
         complete   <= 1'b0;
         busy       <= 1'b0;
         busy_timer <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         data       <= data_nxt;
         ack        <= ack_nxt;
         complete   <= complete_nxt;
         busy       <= (state_nxt != IDLE);
         busy_timer <= (state_nxt == WAIT_DONE) && counting;
         if (dly_load)
            dly_q <= delay;
      end
   end
endmodule
